// File: rtl/seven_seg_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan
// Description : Multiplexed hex seven-segment scanner with guard gaps,
//               double-buffered display data and leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan #(
    parameter int DIGITS     = 4,
    parameter int DIV        = 1000,
    parameter int GUARD      = 2,
    parameter int SEG_INVERT = 0,
    parameter int DIG_INVERT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  lz_en,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_done
);

    localparam int c_cnt_max = (DIV > GUARD) ? DIV : GUARD;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam int c_idx_w   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_cnt_w-1:0] c_div_last   = c_cnt_w'(DIV - 1);
    localparam logic [c_cnt_w-1:0] c_guard_last = c_cnt_w'(GUARD - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(DIGITS - 1);
    localparam logic [c_idx_w-1:0] c_idx_one    = c_idx_w'(1);

    // Inactive output levels; XOR with these applies the optional inversion.
    localparam logic [6:0]        c_seg_off = (SEG_INVERT != 0) ? 7'h7F : 7'h00;
    localparam logic              c_dp_off  = (SEG_INVERT != 0);
    localparam logic [DIGITS-1:0] c_dig_off = (DIG_INVERT != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    typedef enum logic [0:0] {
        ST_GUARD = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [c_idx_w-1:0]    idx_q, idx_d;
    logic [c_cnt_w-1:0]    cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   stage_val_q, stage_val_d;
    logic [DIGITS-1:0]     stage_dp_q, stage_dp_d;
    logic                  pending_q, pending_d;
    logic [4*DIGITS-1:0]   disp_val_q, disp_val_d;
    logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
    logic [6:0]            seg_q, seg_d;
    logic                  seg_dp_q, seg_dp_d;
    logic [DIGITS-1:0]     dig_en_q, dig_en_d;
    logic                  frame_done_q, frame_done_d;

    logic                  w_xfer;
    logic                  w_zero_run;
    logic [DIGITS-1:0]     w_blank;
    logic [3:0]            w_nib;
    logic                  w_dp_bit;
    logic                  w_blank_sel;
    logic                  w_lit;
    logic [DIGITS-1:0]     w_dig_raw;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'b1111110;
            4'h1: decode = 7'b0110000;
            4'h2: decode = 7'b1101101;
            4'h3: decode = 7'b1111001;
            4'h4: decode = 7'b0110011;
            4'h5: decode = 7'b1011011;
            4'h6: decode = 7'b1011111;
            4'h7: decode = 7'b1110000;
            4'h8: decode = 7'b1111111;
            4'h9: decode = 7'b1111011;
            4'hA: decode = 7'b1110111;
            4'hB: decode = 7'b0011111;
            4'hC: decode = 7'b1001110;
            4'hD: decode = 7'b0111101;
            4'hE: decode = 7'b1001111;
            default: decode = 7'b1000111;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q + c_cnt_one;
        stage_val_d  = stage_val_q;
        stage_dp_d   = stage_dp_q;
        pending_d    = pending_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        w_zero_run   = 1'b1;
        w_blank      = '0;
        w_nib        = 4'h0;
        w_dp_bit     = 1'b0;
        w_blank_sel  = 1'b0;
        w_dig_raw    = '0;

        case (state_q)
            ST_GUARD: begin
                if (cnt_q == c_guard_last) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == c_div_last) begin
                    state_d = ST_GUARD;
                    cnt_d   = '0;
                    idx_d   = (idx_q == c_idx_last) ? '0 : idx_q + c_idx_one;
                end
            end
            default: begin
                state_d = ST_GUARD;
                cnt_d   = '0;
            end
        endcase

        frame_done_d = (state_q == ST_SHOW) && (cnt_q == c_div_last) && (idx_q == c_idx_last);

        // Display only swaps at the start of digit 0, so a frame is never torn.
        w_xfer = (state_q == ST_GUARD) && (cnt_q == c_guard_last) && (idx_q == '0) && pending_q;
        if (w_xfer) begin
            disp_val_d = stage_val_q;
            disp_dp_d  = stage_dp_q;
            pending_d  = 1'b0;
        end
        if (load) begin
            stage_val_d = value;
            stage_dp_d  = dp;
            pending_d   = 1'b1;
        end

        // A digit is a leading zero when it and every digit above it is zero.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run & (disp_val_d[4*i +: 4] == 4'h0);
            if (i != 0) begin
                w_blank[i] = lz_en & w_zero_run;
            end
        end

        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == c_idx_w'(i)) begin
                w_nib       = disp_val_d[4*i +: 4];
                w_dp_bit    = disp_dp_d[i];
                w_blank_sel = w_blank[i];
            end
        end

        w_lit = (state_d == ST_SHOW) && !w_blank_sel;
        for (int i = 0; i < DIGITS; i++) begin
            w_dig_raw[i] = w_lit && (idx_d == c_idx_w'(i));
        end

        seg_d    = (w_lit ? decode(w_nib) : 7'h00) ^ c_seg_off;
        seg_dp_d = (w_lit & w_dp_bit) ^ c_dp_off;
        dig_en_d = w_dig_raw ^ c_dig_off;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_GUARD;
            idx_q        <= '0;
            cnt_q        <= '0;
            stage_val_q  <= '0;
            stage_dp_q   <= '0;
            pending_q    <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            seg_q        <= c_seg_off;
            seg_dp_q     <= c_dp_off;
            dig_en_q     <= c_dig_off;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            stage_val_q  <= stage_val_d;
            stage_dp_q   <= stage_dp_d;
            pending_q    <= pending_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            seg_q        <= seg_d;
            seg_dp_q     <= seg_dp_d;
            dig_en_q     <= dig_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign seg_dp     = seg_dp_q;
    assign dig_en     = dig_en_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter DIV, default 1000, clock cycles each digit is lit; legal value >= 1.
REQ-003 Parameter GUARD, default 2, all-dark cycles between digits (anti-ghosting); legal value >= 1.
REQ-004 Parameter SEG_INVERT, default 0, 1 = segment outputs (seg, seg_dp) active-low.
REQ-005 Parameter DIG_INVERT, default 0, 1 = dig_en active-low.
REQ-006 clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 load  input  1  capture value/dp into staging when high.
REQ-009 value  input  4*DIGITS  hex nibbles; value[3:0] = digit 0 (rightmost).
REQ-010 dp  input  DIGITS  decimal point per digit; dp[i] belongs to digit i.
REQ-011 lz_en  input  1  leading-zero suppression enable; sampled every cycle.
REQ-012 seg  output  7  segments {a,b,c,d,e,f,g}, a = MSB.
REQ-013 seg_dp  output  1  decimal-point segment.
REQ-014 dig_en  output  DIGITS  digit enables, one-hot or all-inactive.
REQ-015 frame_done  output  1  one-cycle pulse at end of each full scan.

Function
REQ-016 Decode (pre-inversion, a..g): 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011 6=1011111 7=1110000 8=1111111 9=1111011 A=1110111 B=0011111 C=1001110 D=0111101 E=1001111 F=1000111.
REQ-017 FSM states GUARD and SHOW, plus digit index idx (0..DIGITS-1) and cycle counter cnt.
REQ-018 GUARD lasts exactly GUARD cycles, then SHOW with same idx; SHOW lasts exactly DIV cycles, then GUARD with idx+1, wrapping DIGITS-1 -> 0.
REQ-019 Frame period = DIGITS*(DIV+GUARD) cycles; digit order 0,1,..,DIGITS-1.
REQ-020 Outputs are registered and Moore: in SHOW(idx) dig_en[idx] active, seg/seg_dp = decode of display nibble idx and display dp[idx]; in GUARD dig_en all inactive, seg and seg_dp inactive.
REQ-021 frame_done is high for exactly the one cycle following the last SHOW cycle of idx = DIGITS-1 (first GUARD cycle of the new frame); never otherwise.
REQ-022 Double buffering: load=1 copies value/dp into staging and sets pending; later loads overwrite staging.
REQ-023 On the GUARD->SHOW transition with idx = 0, if pending, staging is copied to the display register and pending clears; display never changes mid-frame.
REQ-024 A load in the same cycle as the REQ-023 transfer goes to staging, keeps pending set, and is displayed from the next frame.
REQ-025 lz_en=1: display digit i (i>=1) is blanked if it and all higher display nibbles are zero; digit 0 never blanked; blanked digit: dig_en inactive, segments inactive, timing unchanged.
REQ-026 Blanking uses the display register (not staging) and current lz_en.
REQ-027 Inversion applied at the output register only: SEG_INVERT complements seg and seg_dp; DIG_INVERT complements dig_en; "inactive" means the inverted level when inverted.
REQ-028 Counters sized to hold max(DIV,GUARD)-1 and DIGITS-1; no overflow or skipped states for any legal parameter set, including DIGITS=1 and DIV=GUARD=1.

Reset
REQ-029 While rst_n=0 at a rising edge: state GUARD, idx=0, cnt=0, staging=display=0, dp registers=0, pending=0, seg/seg_dp/dig_en inactive, frame_done=0.
REQ-030 Reset asserted mid-operation takes effect at the next edge regardless of state; first dig_en[0] occurs GUARD cycles after the first edge with rst_n=1, showing digit value 0 (1111110).
REQ-031 load during reset is ignored.

Verification
REQ-032 Reset 3 cycles, SEG_INVERT=DIG_INVERT=0 -> seg=0000000, seg_dp=0, dig_en=0000, frame_done=0; dig_en=0001 starts exactly GUARD cycles after release.
REQ-033 DIGITS=4 DIV=4 GUARD=2, load value=16'h12AF dp=4'b0100 -> next frame: digit0 1000111, digit1 1110111, digit2 1101101 with seg_dp=1, digit3 0110000, each 4 cycles with 2 dark between; frame_done every 24 cycles.
REQ-034 lz_en=1, value=16'h0005 -> dig_en[3:1] never active, digit0 shows 1011011; value=16'h0000 -> only digit0 active, shows 1111110; value=16'h0300 -> digits 2,1,0 active.
REQ-035 Load 16'h1234 during SHOW(idx=2) of a frame showing 16'hABCD -> digits 2,3 still show B,A that frame; 1234 appears from next digit 0; load on the exact transfer cycle appears one frame later.
REQ-036 SEG_INVERT=1 DIG_INVERT=1 -> GUARD: seg=1111111, seg_dp=1, dig_en=1111; SHOW digit 8 -> seg=0000000, dig_en[idx]=0 only.
REQ-037 rst_n low for 1 cycle during SHOW(idx=2) -> next cycle all outputs inactive, pending cleared, scan restarts at idx 0 with value 0.
